scan_crypt_stream: RTL
======================

// Module: scan_crypt_stream
// PURPOSE
//  Parametrised, double-buffered successor of the scan-path SIPO->cipher->PISO block for 3D-IC die-level scan.
//  - Deserialises scan data into BLOCK_W-bit blocks and hands each block to an external block-cipher core.
//  - Re-serialises the returned ciphertext. The next block is captured while the current one shifts out.
//  - Keeps a running CRC integrity signature over the plaintext, and offers a 1-cycle bypass mode.
// PARAMETERS
//  BLOCK_W   128      block width in bits; any value >= 8
//  SIG_W     16       integrity signature width
//  SIG_POLY  16'h1021 CRC polynomial, MSB-first; the implicit top term is omitted
//  SIG_INIT  16'hFFFF CRC seed, loaded on reset and whenever start is low
// PORTS
//  clk         in   1        single clock, rising edge
//  reset_n     in   1        asynchronous, active-low reset
//  en          in   1        scan shift enable; one bit in and one bit out per cycle while high
//  start       in   1        frame enable (level); low = synchronous soft abort
//  bypass      in   1        1 = plaintext bypass; sampled only at block boundaries
//  serial_in   in   1        scan data in, MSB of each block first
//  serial_out  out  1        scan data out, MSB of each block first
//  blk_data_o  out  BLOCK_W  captured plaintext block, sent to the cipher
//  blk_valid_o out  1        block-valid handshake to the cipher
//  blk_ready_i in   1        cipher accepts the block
//  res_data_i  in   BLOCK_W  ciphertext block from the cipher
//  res_valid_i in   1        ciphertext valid
//  res_ready_o out  1        output buffer is empty and can load
//  frame_done  out  1        1-cycle pulse after the last ciphertext bit of a block leaves
//  ovf         out  1        sticky: an input bit arrived while the capture buffer was full
//  busy        out  1        capture or output buffer holds data, or a handshake is pending
//  sig_o       out  SIG_W    running CRC over all accepted plaintext bits
// BEHAVIOUR
//  Reset (async, reset_n=0) values:
//  - serial_out=0, blk_valid_o=0, res_ready_o=1, frame_done=0, ovf=0, busy=0, sig_o=SIG_INIT.
//  - Both FSMs go to their idle states.
//  Capture FSM: FILL -> HANDOFF -> FILL.
//  - FILL: when en&start, in_sr<={in_sr,serial_in}, in_cnt++, and the CRC absorbs serial_in.
//  - FILL: on the BLOCK_W-th bit, go to HANDOFF. blk_valid_o=1 on the next cycle, blk_data_o=in_sr.
//  - HANDOFF: blk_data_o and blk_valid_o stay stable until blk_valid_o&blk_ready_i.
//  - HANDOFF: that handshake returns the FSM to FILL with in_cnt=0.
//  - HANDOFF: en=1 drops the bit and sets ovf. in_sr and the CRC are unchanged.
//  - Handshake and new bit in the same cycle: the handshake wins, the bit is dropped, ovf is set.
//  Output FSM: EMPTY -> SHIFT.
//  - EMPTY: res_ready_o=1. res_valid_i&res_ready_o loads out_sr, out_cnt=BLOCK_W, state goes to SHIFT.
//  - SHIFT: res_ready_o=0. serial_out=out_sr[BLOCK_W-1] (flop output).
//  - SHIFT: each en&start cycle shifts out_sr left and decrements out_cnt.
//  - SHIFT: on the last bit, frame_done pulses on the next cycle and the state returns to EMPTY.
//  - EMPTY: serial_out=0.
//  Latency: the first ciphertext bit is on serial_out the cycle after the load.
//  - No en is needed to present it; en advances to the next bit.
//  Bypass:
//  - bypass is latched when in_cnt==0 and out_cnt==0; a mid-block change is ignored.
//  - In bypass, serial_out <= serial_in when en&start, i.e. 1-cycle latency.
//  - In bypass, blk_valid_o stays 0, res_ready_o stays 0, and the CRC still accumulates.
//  start=0 (sync abort):
//  - Clears in_cnt, out_cnt and ovf. Loads sig_o=SIG_INIT. Both FSMs go idle.
//  - Drops blk_valid_o. serial_out=0.
//  - A ciphertext returned later is loaded normally.
//  Width rules:
//  - Counters are $clog2(BLOCK_W+1) bits and never wrap.
//  - CRC step per bit: fb=sig[SIG_W-1]^bit; sig=(sig<<1)^(fb?SIG_POLY:0).
// STRUCTURE
//  Package scan_crypt_pkg holds:
//  - capture/output state enums
//  - default SIG_POLY/SIG_INIT
//  - counter-width function
//  Sub-module scan_crc_accum (SIG_W, SIG_POLY, SIG_INIT): bit-serial CRC with en/clr inputs.
//  The cipher core stays external.
// TESTING
//  1 reset_n=0 mid-shift -> every output at its reset value immediately; sig_o=16'hFFFF.
//  2 en=start=1, 128 bits of 0xAAAA..AA; blk_ready_i=0 for 5 cycles.
//    -> blk_valid_o=1 from the cycle after the 128th bit; blk_data_o=128'hAAAA..AA stable through the stall.
//    -> extra en bits during the stall set ovf=1.
//  3 res_data_i=128'h0123456789abcdef0123456789abcdef with res_valid_i for 1 cycle, then en=1.
//    -> serial_out streams 0,0,0,0,0,0,0,1,... (128 bits); frame_done pulses once; res_ready_o=1 again.
//  4 Back-to-back blocks: block 2 shifts in while block 1 shifts out.
//    -> ciphertext 1 is intact, blk_data_o=block 2, ovf=0.
//  5 bypass=1, shift ASCII "123456789" (72 bits, MSB-first).
//    -> serial_out=serial_in delayed 1 cycle; blk_valid_o never rises; sig_o=16'h29B1.
//  6 start=0 for 1 cycle at bit 60 of a block.
//    -> in_cnt=0, ovf=0, sig_o=16'hFFFF; the next 128 bits form a complete fresh block.

Source files
------------

// File: rtl/scan_crypt_pkg.sv
// Shared types and defaults for the scan-path cipher streaming block.
// Holds FSM state enums, CRC defaults and the counter-width helper.
package scan_crypt_pkg;

  typedef enum logic {
    CAP_FILL    = 1'b0,
    CAP_HANDOFF = 1'b1
  } cap_state_e;

  typedef enum logic {
    OUT_EMPTY = 1'b0,
    OUT_SHIFT = 1'b1
  } out_state_e;

  localparam logic [15:0] DEF_SIG_POLY = 16'h1021;
  localparam logic [15:0] DEF_SIG_INIT = 16'hFFFF;

  // Counters must hold the value BLOCK_W itself, hence the +1.
  function automatic int cnt_w(input int block_w);
    return $clog2(block_w + 1);
  endfunction

endpackage

// File: rtl/scan_crc_accum.sv
// Bit-serial MSB-first CRC accumulator; clr reloads the seed and wins over en.
module scan_crc_accum #(
  parameter int               SIG_W    = 16,
  parameter logic [SIG_W-1:0] SIG_POLY = SIG_W'(16'h1021),
  parameter logic [SIG_W-1:0] SIG_INIT = SIG_W'(16'hFFFF)
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             en,
  input  logic             clr,
  input  logic             bit_in,
  output logic [SIG_W-1:0] sig
);

  logic fb;

  assign fb = sig[SIG_W-1] ^ bit_in;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sig <= SIG_INIT;
    end else if (clr) begin
      sig <= SIG_INIT;
    end else if (en) begin
      sig <= {sig[SIG_W-2:0], 1'b0} ^ (fb ? SIG_POLY : '0);
    end
  end

endmodule

// File: rtl/scan_crypt_stream.sv
// Double-buffered scan SIPO -> external cipher -> PISO with running CRC and bypass.
// Capture and output FSMs run independently so a block can fill while the previous one drains.
module scan_crypt_stream
  import scan_crypt_pkg::*;
#(
  parameter int               BLOCK_W  = 128,
  parameter int               SIG_W    = 16,
  parameter logic [SIG_W-1:0] SIG_POLY = SIG_W'(DEF_SIG_POLY),
  parameter logic [SIG_W-1:0] SIG_INIT = SIG_W'(DEF_SIG_INIT)
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               en,
  input  logic               start,
  input  logic               bypass,
  input  logic               serial_in,
  output logic               serial_out,
  output logic [BLOCK_W-1:0] blk_data_o,
  output logic               blk_valid_o,
  input  logic               blk_ready_i,
  input  logic [BLOCK_W-1:0] res_data_i,
  input  logic               res_valid_i,
  output logic               res_ready_o,
  output logic               frame_done,
  output logic               ovf,
  output logic               busy,
  output logic [SIG_W-1:0]   sig_o,
  output cap_state_e         cap_state_dbg,
  output out_state_e         out_state_dbg
);

  // Handshakes: a transfer happens on a cycle where valid & ready are both high;
  // valid holds with stable data until it does, ready never depends on valid.

  localparam int              CW       = cnt_w(BLOCK_W);
  localparam logic [CW-1:0]   CNT_LAST = CW'(BLOCK_W - 1);
  localparam logic [CW-1:0]   CNT_FULL = CW'(BLOCK_W);
  localparam logic [CW-1:0]   CNT_ONE  = CW'(1);

  cap_state_e         cap_state, cap_next;
  out_state_e         out_state, out_next;
  logic [BLOCK_W-1:0] in_sr, out_sr;
  logic [CW-1:0]      in_cnt, out_cnt;
  logic               bypass_q, bypass_eff, byp_bit;
  logic               step, bit_take, cap_hs, out_load, out_step;

  assign step = en & start;
  // Mode can only change at a block boundary (both counters empty) or during abort.
  assign bypass_eff = (!start || (in_cnt == '0 && out_cnt == '0)) ? bypass : bypass_q;

  assign blk_valid_o   = (cap_state == CAP_HANDOFF) & start;
  assign blk_data_o    = in_sr;
  assign res_ready_o   = (out_state == OUT_EMPTY) & ~bypass_q;
  assign serial_out    = bypass_q ? byp_bit : ((out_state == OUT_SHIFT) & out_sr[BLOCK_W-1]);
  assign busy          = (in_cnt != '0) | (cap_state == CAP_HANDOFF) | (out_state == OUT_SHIFT);
  assign cap_state_dbg = cap_state;
  assign out_state_dbg = out_state;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cap_state <= CAP_FILL;
      out_state <= OUT_EMPTY;
    end else begin
      cap_state <= cap_next;
      out_state <= out_next;
    end
  end

  always_comb begin
    cap_next = cap_state;
    out_next = out_state;
    bit_take = 1'b0;
    cap_hs   = 1'b0;
    out_load = 1'b0;
    out_step = 1'b0;
    case (cap_state)
      CAP_FILL: begin
        bit_take = step;
        if (step && !bypass_eff && in_cnt == CNT_LAST) cap_next = CAP_HANDOFF;
      end
      CAP_HANDOFF: begin
        cap_hs = blk_valid_o & blk_ready_i;
        if (cap_hs) cap_next = CAP_FILL;
      end
      default: cap_next = CAP_FILL;
    endcase
    case (out_state)
      OUT_EMPTY: begin
        out_load = res_valid_i & res_ready_o;
        if (out_load) out_next = OUT_SHIFT;
      end
      OUT_SHIFT: begin
        out_step = step;
        if (!start || (step && out_cnt == CNT_ONE)) out_next = OUT_EMPTY;
      end
      default: out_next = OUT_EMPTY;
    endcase
    if (!start) cap_next = CAP_FILL;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      in_sr      <= '0;
      out_sr     <= '0;
      in_cnt     <= '0;
      out_cnt    <= '0;
      bypass_q   <= 1'b0;
      byp_bit    <= 1'b0;
      frame_done <= 1'b0;
      ovf        <= 1'b0;
    end else begin
      bypass_q   <= bypass_eff;
      frame_done <= out_step && (out_cnt == CNT_ONE);
      if (!start) ovf <= 1'b0;
      else if (cap_state == CAP_HANDOFF && en) ovf <= 1'b1;
      // In bypass the counter only marks block boundaries, so it rolls over instead of handing off.
      if (!start || cap_hs) in_cnt <= '0;
      else if (bit_take) in_cnt <= (bypass_eff && in_cnt == CNT_LAST) ? '0 : in_cnt + CNT_ONE;
      if (bit_take && !bypass_eff) in_sr <= {in_sr[BLOCK_W-2:0], serial_in};
      if (out_load) begin
        out_sr  <= res_data_i;
        out_cnt <= CNT_FULL;
      end else if (!start) begin
        out_cnt <= '0;
      end else if (out_step) begin
        out_sr  <= {out_sr[BLOCK_W-2:0], 1'b0};
        out_cnt <= out_cnt - CNT_ONE;
      end
      if (!start) byp_bit <= 1'b0;
      else if (step && bypass_eff) byp_bit <= serial_in;
    end
  end

  scan_crc_accum #(
    .SIG_W   (SIG_W),
    .SIG_POLY(SIG_POLY),
    .SIG_INIT(SIG_INIT)
  ) u_crc (
    .clk    (clk),
    .reset_n(reset_n),
    .en     (bit_take),
    .clr    (~start),
    .bit_in (serial_in),
    .sig    (sig_o)
  );

endmodule
